instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, fetch address loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iaddr  output 16  byte address driven to instruction memory; equals fetch_pc register.
REQ-005 idata  input  16  instruction word returned combinationally by instruction memory for the current iaddr.
REQ-006 fetch_en  input  1  1 = fetching permitted; 0 = no new pushes.
REQ-007 br_taken  input  1  one-cycle redirect request from execute.
REQ-008 br_target  input  16  redirect byte address; sampled only when br_taken=1.
REQ-009 stall  input  1  downstream decode not ready to accept inst.
REQ-010 inst  output 16  instruction at head of prefetch buffer.
REQ-011 inst_pc  output 16  byte address of inst.
REQ-012 inst_valid  output 1  inst/inst_pc hold a valid entry.

Function
REQ-013 The block SHALL contain fetch_pc (16 bits), a 2-entry FIFO of {pc, instruction} pairs, and an FSM with states IDLE, FETCH, FULL.
REQ-014 iaddr SHALL equal fetch_pc with bit 0 always 0; no combinational path from any input to iaddr.
REQ-015 Push condition: state != IDLE, fetch_en=1, br_taken=0, and (count<2 or pop this cycle).
REQ-016 On push, {fetch_pc, idata} SHALL be written at the FIFO tail and fetch_pc SHALL advance by 2, wrapping 16'hFFFE -> 16'h0000.
REQ-017 Pop condition: inst_valid=1, stall=0, br_taken=0; the head entry SHALL be removed at the clock edge.
REQ-018 Push and pop in the same cycle with count=2 SHALL both occur; count stays 2.
REQ-019 inst, inst_pc, inst_valid SHALL be driven from FIFO head registers only (registered outputs); with count=0 inst_valid=0, and inst/inst_pc hold 16'h0000.
REQ-020 Fetch-to-output latency: an instruction addressed at cycle N SHALL appear on inst with inst_valid=1 at cycle N+1 if FIFO was empty.
REQ-021 Redirect: br_taken=1 SHALL flush the FIFO (count=0), load fetch_pc with {br_target[15:1],1'b0}, suppress push and pop that cycle; inst_valid=0 the next cycle.
REQ-022 br_taken SHALL take priority over stall, fetch_en, and FIFO state.
REQ-023 FSM: IDLE -> FETCH one cycle after reset release; FETCH -> FULL when count becomes 2; FULL -> FETCH when count drops below 2 or on br_taken; any state -> IDLE on reset.
REQ-024 fetch_en=0 SHALL only block pushes; pops and redirects continue normally.
REQ-025 stall=1 with count=2 and no pop SHALL hold fetch_pc and FIFO contents unchanged indefinitely.

Reset
REQ-026 On reset=1 at a clock edge: fetch_pc=RESET_PC, count=0, state=IDLE, inst_valid=0, inst=16'h0000, inst_pc=16'h0000, regardless of other inputs.
REQ-027 Reset asserted mid-stream SHALL discard all buffered entries and any simultaneous br_taken.
REQ-028 First push SHALL occur in the second cycle after reset deassertion (address RESET_PC).

Verification
REQ-029 Reset, fetch_en=1, stall=0, memory returns word = address -> inst_pc sequence 0,2,4,6 on consecutive cycles, inst_valid=1 from cycle 2 onward.
REQ-030 Stream running, stall=1 for 5 cycles -> count reaches 2, iaddr frozen, inst/inst_pc unchanged; stall=0 -> entries drain in order with no gap or duplicate.
REQ-031 br_taken=1, br_target=16'h0021 while count=2 -> next cycle inst_valid=0, iaddr=16'h0020; following cycle inst_pc=16'h0020.
REQ-032 RESET_PC=16'hFFFC, free run -> inst_pc sequence FFFC, FFFE, 0000, 0002.
REQ-033 br_taken=1 and stall=1 simultaneously with count=1 -> flush and redirect occur; old head never accepted.
REQ-034 reset=1 while count=2 and br_taken=1 -> next cycle iaddr=RESET_PC, inst_valid=0, state IDLE.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage with a 2-entry prefetch buffer of {pc, instruction}
// pairs. fetch_pc addresses instruction memory directly; the memory answers
// combinationally on idata and the pair is pushed at the buffer tail. The
// buffer head is presented to decode on inst/inst_pc/inst_valid. A taken
// branch from execute flushes the buffer and redirects fetch_pc.
//
// Ports:
//   clock       in   single clock, rising-edge state updates
//   reset       in   synchronous active-high reset
//   iaddr       out  [15:0] byte address to instruction memory (bit 0 = 0)
//   idata       in   [15:0] instruction word for the current iaddr
//   fetch_en    in   1 = new pushes permitted
//   br_taken    in   redirect request (one cycle)
//   br_target   in   [15:0] redirect byte address
//   stall       in   decode not ready to accept inst
//   inst        out  [15:0] instruction at buffer head
//   inst_pc     out  [15:0] byte address of inst
//   inst_valid  out  head entry is valid
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] iaddr,
    input  logic [15:0] idata,
    input  logic        fetch_en,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        stall,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] fetch_pc, fetch_pc_nx;
    logic [15:0] head_pc, head_pc_nx;
    logic [15:0] head_ins, head_ins_nx;
    logic [15:0] tail_pc, tail_pc_nx;
    logic [15:0] tail_ins, tail_ins_nx;
    logic [1:0]  count, count_nx;
    logic        push, pop;

    // Outputs come straight from registers; no input reaches them combinationally.
    assign iaddr      = {fetch_pc[15:1], 1'b0};
    assign inst       = head_ins;
    assign inst_pc    = head_pc;
    assign inst_valid = (count != 2'd0);

    always_comb begin
        pop  = (count != 2'd0) && !stall && !br_taken;
        push = (state != IDLE) && fetch_en && !br_taken &&
               ((count != 2'd2) || pop);

        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        head_pc_nx  = head_pc;
        head_ins_nx = head_ins;
        tail_pc_nx  = tail_pc;
        tail_ins_nx = tail_ins;
        count_nx    = count;

        if (br_taken) begin
            // Flush; entries are cleared so an empty buffer reads as zero.
            fetch_pc_nx = br_target & 16'hFFFE;
            head_pc_nx  = '0;
            head_ins_nx = '0;
            tail_pc_nx  = '0;
            tail_ins_nx = '0;
            count_nx    = 2'd0;
        end else begin
            if (push) begin
                fetch_pc_nx = iaddr + 16'd2;
            end
            // The tail slot is kept zero whenever it is empty, so shifting it
            // into the head on a pop is correct for both count=1 and count=2.
            if (pop && !push) begin
                head_pc_nx  = tail_pc;
                head_ins_nx = tail_ins;
                tail_pc_nx  = '0;
                tail_ins_nx = '0;
                count_nx    = count - 2'd1;
            end else if (push && !pop) begin
                if (count == 2'd0) begin
                    head_pc_nx  = iaddr;
                    head_ins_nx = idata;
                end else begin
                    tail_pc_nx  = iaddr;
                    tail_ins_nx = idata;
                end
                count_nx = count + 2'd1;
            end else if (push && pop) begin
                if (count == 2'd2) begin
                    head_pc_nx  = tail_pc;
                    head_ins_nx = tail_ins;
                    tail_pc_nx  = iaddr;
                    tail_ins_nx = idata;
                end else begin
                    head_pc_nx  = iaddr;
                    head_ins_nx = idata;
                end
            end
        end

        unique case (state)
            IDLE:    state_nx = FETCH;
            FETCH:   state_nx = (count_nx == 2'd2) ? FULL : FETCH;
            FULL:    state_nx = (br_taken || count_nx != 2'd2) ? FETCH : FULL;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            head_pc  <= '0;
            head_ins <= '0;
            tail_pc  <= '0;
            tail_ins <= '0;
            count    <= 2'd0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            head_pc  <= head_pc_nx;
            head_ins <= head_ins_nx;
            tail_pc  <= tail_pc_nx;
            tail_ins <= tail_ins_nx;
            count    <= count_nx;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A queue-based reference model tracks
// the prefetch buffer contents and fetch address; directed scenarios check
// fixed expected values, and a randomized run compares the DUT with the model
// every cycle. A second instance with RESET_PC=16'hFFFC covers address wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset, fetch_en, br_taken, stall;
    logic [15:0] br_target;
    logic [15:0] iaddr, idata, inst, inst_pc;
    logic        inst_valid;
    logic [15:0] iaddr_hi, idata_hi, inst_hi, inst_pc_hi;
    logic        inst_valid_hi;
    logic [15:0] key = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [15:0] pc_m;
    bit          idle_m;

    always #5 clock = ~clock;

    assign idata    = iaddr ^ key;
    assign idata_hi = iaddr_hi ^ key;

    instr_fetch u_dut (
        .clock(clock), .reset(reset), .iaddr(iaddr), .idata(idata),
        .fetch_en(fetch_en), .br_taken(br_taken), .br_target(br_target),
        .stall(stall), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
    );

    instr_fetch #(.RESET_PC(16'hFFFC)) u_hi (
        .clock(clock), .reset(reset), .iaddr(iaddr_hi), .idata(idata_hi),
        .fetch_en(fetch_en), .br_taken(br_taken), .br_target(br_target),
        .stall(stall), .inst(inst_hi), .inst_pc(inst_pc_hi), .inst_valid(inst_valid_hi)
    );

    // Drive one cycle of inputs (called at a falling edge), advance the model
    // by the spec rules, and return at the next falling edge.
    task automatic drive(input logic r, input logic fe, input logic bt,
                         input logic [15:0] bta, input logic st);
        logic [15:0] a;
        bit          do_pop, do_push;
        reset = r; fetch_en = fe; br_taken = bt; br_target = bta; stall = st;
        if (r) begin
            q.delete();
            pc_m   = 16'h0000;
            idle_m = 1'b1;
        end else if (bt) begin
            q.delete();
            pc_m   = bta & 16'hFFFE;
            idle_m = 1'b0;
        end else begin
            a       = pc_m & 16'hFFFE;
            do_pop  = (q.size() != 0) && !st;
            do_push = !idle_m && fe && ((q.size() < 2) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back({a, a ^ key});
                pc_m = a + 16'd2;
            end
            idle_m = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
        n_tests++;
        if (iaddr !== 16'h0000) begin
            n_fail++; $display("FAIL reset_iaddr: got %h expected %h", iaddr, 16'h0000);
        end
        n_tests++;
        if (inst_valid !== 1'b0 || inst !== 16'h0000 || inst_pc !== 16'h0000) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b inst=%h pc=%h expected v=0 inst=0000 pc=0000",
                               inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_stream;
        logic [15:0] e;
        key = 16'h0000;
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
            n_tests++;
            if (i == 0) begin
                if (inst_valid !== 1'b0) begin
                    n_fail++; $display("FAIL stream_first_cycle: got v=%b expected v=0", inst_valid);
                end
            end else begin
                e = 16'(2 * (i - 1));
                if (inst_valid !== 1'b1 || inst_pc !== e || inst !== e) begin
                    n_fail++; $display("FAIL stream_seq%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                                       i, inst_valid, inst_pc, inst, e, e);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [15:0] drain [4];
        drain = '{16'h000A, 16'h000C, 16'h000E, 16'h0010};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
            n_tests++;
            if (iaddr !== 16'h000C || inst_pc !== 16'h0008 || inst !== 16'h0008 || inst_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d: got iaddr=%h pc=%h inst=%h v=%b expected iaddr=000c pc=0008 inst=0008 v=1",
                                   i, iaddr, inst_pc, inst, inst_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
            n_tests++;
            if (inst_valid !== 1'b1 || inst_pc !== drain[i]) begin
                n_fail++; $display("FAIL stall_drain%0d: got v=%b pc=%h expected v=1 pc=%h",
                                   i, inst_valid, inst_pc, drain[i]);
            end
        end
    endtask

    task automatic test_redirect;
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 16'h0021, 1'b0);
        n_tests++;
        if (inst_valid !== 1'b0 || iaddr !== 16'h0020) begin
            n_fail++; $display("FAIL redirect_flush: got v=%b iaddr=%h expected v=0 iaddr=0020", inst_valid, iaddr);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0020 || inst !== 16'h0020) begin
            n_fail++; $display("FAIL redirect_target: got v=%b pc=%h inst=%h expected v=1 pc=0020 inst=0020",
                               inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_br_stall;
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0020) begin
            n_fail++; $display("FAIL brstall_pre: got v=%b pc=%h expected v=1 pc=0020", inst_valid, inst_pc);
        end
        drive(1'b0, 1'b1, 1'b1, 16'h0101, 1'b1);
        n_tests++;
        if (inst_valid !== 1'b0 || iaddr !== 16'h0100) begin
            n_fail++; $display("FAIL brstall_flush: got v=%b iaddr=%h expected v=0 iaddr=0100", inst_valid, iaddr);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0100) begin
            n_fail++; $display("FAIL brstall_target: got v=%b pc=%h expected v=1 pc=0100", inst_valid, inst_pc);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 16'h4444, 1'b1);
        n_tests++;
        if (iaddr !== 16'h0000 || inst_valid !== 1'b0 || inst !== 16'h0000 || inst_pc !== 16'h0000) begin
            n_fail++; $display("FAIL resetmid_clear: got iaddr=%h v=%b inst=%h pc=%h expected 0000 0 0000 0000",
                               iaddr, inst_valid, inst, inst_pc);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_tests++;
        if (iaddr !== 16'h0000 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL resetmid_idle: got iaddr=%h v=%b expected iaddr=0000 v=0", iaddr, inst_valid);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_tests++;
        if (iaddr !== 16'h0002 || inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin
            n_fail++; $display("FAIL resetmid_first_push: got iaddr=%h v=%b pc=%h expected iaddr=0002 v=1 pc=0000",
                               iaddr, inst_valid, inst_pc);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_w [4];
        exp_w = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_tests++;
        if (iaddr_hi !== 16'hFFFC || inst_valid_hi !== 1'b0) begin
            n_fail++; $display("FAIL wrap_reset: got iaddr=%h v=%b expected iaddr=fffc v=0", iaddr_hi, inst_valid_hi);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
            n_tests++;
            if (inst_valid_hi !== 1'b1 || inst_pc_hi !== exp_w[i]) begin
                n_fail++; $display("FAIL wrap_seq%0d: got v=%b pc=%h expected v=1 pc=%h",
                                   i, inst_valid_hi, inst_pc_hi, exp_w[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] e_pc, e_ins;
        logic        e_v;
        key = 16'(($urandom() & 16'hFFFF));
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 80),
                  ($urandom_range(0, 99) < 10),
                  16'($urandom()),
                  ($urandom_range(0, 99) < 35));
            e_v   = (q.size() != 0);
            e_pc  = e_v ? q[0][31:16] : 16'h0000;
            e_ins = e_v ? q[0][15:0]  : 16'h0000;
            n_tests++;
            if (inst_valid !== e_v || inst_pc !== e_pc || inst !== e_ins || iaddr !== (pc_m & 16'hFFFE)) begin
                n_fail++; $display("FAIL random_cycle%0d: got v=%b pc=%h inst=%h iaddr=%h expected v=%b pc=%h inst=%h iaddr=%h",
                                   i, inst_valid, inst_pc, inst, iaddr, e_v, e_pc, e_ins, pc_m & 16'hFFFE);
            end
        end
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; br_taken = 1'b0; br_target = '0; stall = 1'b0;
        @(negedge clock);
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_br_stall;
        test_reset_mid;
        test_wrap;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
